// File: rtl/pc_unit.sv
// Program-counter unit: fetch increment, write-back redirect, stall, trap entry/return
// with EPC, and a circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PHASES    = 5,
  parameter int unsigned F_IDX     = 0,
  parameter int unsigned W_IDX     = 4,
  parameter int unsigned INC       = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h80),
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [PHASES-1:0]              phase,
  input  logic                           stall,
  input  logic                           ct_taken,
  input  logic [XLEN-1:0]                dr,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           trap,
  input  logic                           eret,
  output logic [XLEN-1:0]                pc,
  output logic [XLEN-1:0]                epc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH+1);
  localparam logic [PHASES-1:0] F_MASK = PHASES'(1) << F_IDX;
  localparam logic [PHASES-1:0] W_MASK = PHASES'(1) << W_IDX;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_sp;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            r_unf;

  logic            w_is_f;
  logic            w_is_w;
  logic [PW-1:0]   w_sp_inc;
  logic [PW-1:0]   w_sp_dec;
  logic [XLEN-1:0] w_top;
  logic            w_empty;
  logic            w_full;

  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_epc_nxt;
  logic [PW-1:0]   w_sp_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_ras_we;
  logic [PW-1:0]   w_ras_idx;
  logic [XLEN-1:0] w_ras_wd;
  logic            w_ovf_set;
  logic            w_unf_set;

  assign w_is_f   = |(phase & F_MASK);
  assign w_is_w   = |(phase & W_MASK);
  assign w_sp_inc = (r_sp == PW'(RAS_DEPTH-1)) ? '0 : r_sp + PW'(1);
  assign w_sp_dec = (r_sp == '0) ? PW'(RAS_DEPTH-1) : r_sp - PW'(1);
  assign w_top    = r_ras[r_sp];
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CW'(RAS_DEPTH));

  always_comb begin
    w_pc_nxt  = r_pc;
    w_epc_nxt = r_epc;
    w_sp_nxt  = r_sp;
    w_cnt_nxt = r_cnt;
    w_ras_we  = 1'b0;
    w_ras_idx = r_sp;
    w_ras_wd  = r_pc;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (trap) begin
      w_epc_nxt = r_pc;
      w_pc_nxt  = TRAP_VEC;
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else if (w_is_f) begin
      w_pc_nxt = r_pc + XLEN'(INC);
    end else if (w_is_w) begin
      if (eret) begin
        w_pc_nxt = r_epc;
      end else if (ct_taken) begin
        if (ret && !w_empty) begin
          w_pc_nxt = w_top;
          if (call) begin
            w_ras_we = 1'b1;
          end else begin
            w_sp_nxt  = w_sp_dec;
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end else if (call) begin
          // Push slot is always sp+1; when full this lands on the oldest entry.
          w_pc_nxt  = dr;
          w_sp_nxt  = w_sp_inc;
          w_ras_we  = 1'b1;
          w_ras_idx = w_sp_inc;
          w_unf_set = ret;
          if (w_full) w_ovf_set = 1'b1;
          else        w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_pc_nxt  = dr;
          w_unf_set = ret;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pc  <= RESET_VEC;
      r_epc <= '0;
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_epc <= w_epc_nxt;
      r_sp  <= w_sp_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= r_ovf | w_ovf_set;
      r_unf <= r_unf | w_unf_set;
      if (w_ras_we) r_ras[w_ras_idx] <= w_ras_wd;
    end
  end

  assign pc      = r_pc;
  assign epc     = r_epc;
  assign ras_cnt = r_cnt;
  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;

endmodule
